bt_radio_seq: RTL and testbench

- Sequences the BT radio model through one hop per request: program channel, wait PLL settle, enable TX or RX for a programmed window, then guard off.
- Sits between the baseband slot scheduler (requester) and the radio model.
- Drives the radio's k, rxk, loadfreq_p, txen and rxen.
- Skips the settle wait when the requested channel equals the channel already loaded.

---
 rtl/bt_radio_pkg.sv | 28 ++
 rtl/bt_radio_seq_if.sv | 38 +++
 rtl/bt_radio_seq.sv | 201 ++++++++++++++++++++
 tb/tb_bt_radio_seq.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bt_radio_pkg.sv
// -----------------------------------------------------------------------------
// bt_radio_pkg
// Definitions shared by the BT radio hop sequencer and its environment:
//   - state_e  : hop sequencer states (IDLE, LOAD, SETTLE, ACTIVE, GUARD)
//   - BT_MAX_CH: highest legal channel index (2402 + 78 = 2480 MHz)
//   - CLK_MHZ  : sequencer clock rate in MHz
//   - us2cyc() : converts a time in microseconds to clk_6M cycles
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
package bt_radio_pkg;

  localparam int BT_MAX_CH = 78;
  localparam int CLK_MHZ   = 6;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    SETTLE = 3'd2,
    ACTIVE = 3'd3,
    GUARD  = 3'd4
  } state_e;

  // Microseconds to clk_6M cycles, used to derive the PLL settle time.
  function automatic int us2cyc(input int us);
    return us * CLK_MHZ;
  endfunction

endpackage

// File: rtl/bt_radio_seq_if.sv
// -----------------------------------------------------------------------------
// bt_radio_seq_if
// Hop-request handshake between the baseband slot scheduler (master) and the
// radio sequencer (slave).
//   req_valid : hop request valid                      (master -> slave)
//   req_ready : sequencer can accept a request         (slave  -> master)
//   req_tx    : 1 = TX window, 0 = RX window           (master -> slave)
//   req_k     : channel index 0..78                    (master -> slave)
//   req_len   : enable-window length, 0 means 1 cycle  (master -> slave)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
interface bt_radio_seq_if #(
  parameter int LEN_W = 16
);

  logic             req_valid;
  logic             req_ready;
  logic             req_tx;
  logic [6:0]       req_k;
  logic [LEN_W-1:0] req_len;

  modport master (
    output req_valid,
    output req_tx,
    output req_k,
    output req_len,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_tx,
    input  req_k,
    input  req_len,
    output req_ready
  );

endinterface

// File: rtl/bt_radio_seq.sv
// -----------------------------------------------------------------------------
// bt_radio_seq
// Sequences the BT radio through one hop per request: program the channel,
// wait for the PLL to settle, open a TX or RX enable window, then hold a guard
// gap before the next request. The settle wait is skipped when the requested
// channel is already loaded and known good.
// Ports:
//   clk_6M, rstz     : 6 MHz clock, asynchronous active-low reset
//   req              : hop request handshake (slave side)
//   abort            : synchronous abort of the current hop
//   k, rxk           : channel to radio synthesizer / receiver compare
//   loadfreq_p       : one-cycle pulse, load k into the PLL
//   txen, rxen       : radio TX / RX enables (never both high)
//   busy             : sequencer not idle
//   done_p           : one-cycle pulse at the end of an enable window
//   err_p            : one-cycle pulse, request with illegal channel dropped
// All outputs are registered.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module bt_radio_seq
  import bt_radio_pkg::*;
#(
  parameter int SETTLE_CYC = us2cyc(100),
  parameter int GUARD_CYC  = 12,
  parameter int LEN_W      = 16
) (
  input  logic              clk_6M,
  input  logic              rstz,
  bt_radio_seq_if.slave     req,
  input  logic              abort,
  output logic [6:0]        k,
  output logic [6:0]        rxk,
  output logic              loadfreq_p,
  output logic              txen,
  output logic              rxen,
  output logic              busy,
  output logic              done_p,
  output logic              err_p
);

  localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam int GRD_W = (GUARD_CYC > 1) ? $clog2(GUARD_CYC) : 1;
  localparam int MAX_W = (SET_W > GRD_W) ? SET_W : GRD_W;
  localparam int CNT_W = (LEN_W > MAX_W) ? LEN_W : MAX_W;

  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] GUARD_LD  = CNT_W'(GUARD_CYC - 1);
  localparam logic [6:0]       MAX_CH    = 7'(BT_MAX_CH);

  localparam logic [2:0] ST_IDLE   = IDLE;
  localparam logic [2:0] ST_LOAD   = LOAD;
  localparam logic [2:0] ST_SETTLE = SETTLE;
  localparam logic [2:0] ST_ACTIVE = ACTIVE;
  localparam logic [2:0] ST_GUARD  = GUARD;

  // A window of len cycles counts down from len-1; len 0 behaves like len 1.
  function automatic logic [CNT_W-1:0] win_load(input logic [LEN_W-1:0] len);
    logic [CNT_W-1:0] ext;
    ext = CNT_W'(len);
    if (ext == CNT_ZERO) begin
      return CNT_ZERO;
    end else begin
      return ext - CNT_ONE;
    end
  endfunction

  logic [2:0]       state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic             tx_r, tx_s;
  logic [LEN_W-1:0] len_r, len_s;
  logic             cur_k_vld_r, cur_k_vld_s;
  logic [6:0]       k_s, rxk_s;
  logic             loadfreq_s, txen_s, rxen_s, done_s, err_s;
  logic             busy_s, ready_s;

  // Next-state and next-output logic for the hop sequencer.
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    tx_s        = tx_r;
    len_s       = len_r;
    cur_k_vld_s = cur_k_vld_r;
    k_s         = k;
    rxk_s       = rxk;
    loadfreq_s  = 1'b0;
    txen_s      = txen;
    rxen_s      = rxen;
    done_s      = 1'b0;
    err_s       = 1'b0;

    case (state_r)
      ST_IDLE: begin
        // abort in IDLE blocks acceptance for that cycle
        if (req.req_valid && !abort) begin
          tx_s  = req.req_tx;
          len_s = req.req_len;
          if (req.req_k > MAX_CH) begin
            err_s = 1'b1;
          end else if (cur_k_vld_r && (req.req_k == k)) begin
            state_s = ST_ACTIVE;
            cnt_s   = win_load(req.req_len);
            txen_s  = req.req_tx;
            rxen_s  = ~req.req_tx;
          end else begin
            // k/rxk change together with the load pulse in the LOAD cycle
            state_s     = ST_LOAD;
            k_s         = req.req_k;
            rxk_s       = req.req_k;
            loadfreq_s  = 1'b1;
            cur_k_vld_s = 1'b1;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LOAD, ST_SETTLE: begin
        if (abort) begin
          // PLL lock state unknown after an interrupted load
          state_s     = ST_GUARD;
          cnt_s       = GUARD_LD;
          cur_k_vld_s = 1'b0;
        end else if (state_r == ST_LOAD) begin
          state_s = ST_SETTLE;
          cnt_s   = SETTLE_LD;
        end else if (cnt_r == CNT_ZERO) begin
          state_s = ST_ACTIVE;
          cnt_s   = win_load(len_r);
          txen_s  = tx_r;
          rxen_s  = ~tx_r;
        end else begin
          cnt_s = cnt_r - CNT_ONE;
        end
      end
      ST_ACTIVE: begin
        if (abort || (cnt_r == CNT_ZERO)) begin
          state_s = ST_GUARD;
          cnt_s   = GUARD_LD;
          txen_s  = 1'b0;
          rxen_s  = 1'b0;
          done_s  = 1'b1;
        end else begin
          cnt_s = cnt_r - CNT_ONE;
        end
      end
      ST_GUARD: begin
        if (cnt_r == CNT_ZERO) begin
          state_s = ST_IDLE;
        end else begin
          cnt_s = cnt_r - CNT_ONE;
        end
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = CNT_ZERO;
        txen_s  = 1'b0;
        rxen_s  = 1'b0;
      end
    endcase

    busy_s  = (state_s != ST_IDLE);
    ready_s = (state_s == ST_IDLE);
  end

  // State, counter, latched request fields and registered outputs.
  always_ff @(posedge clk_6M or negedge rstz) begin
    if (!rstz) begin
      state_r       <= ST_IDLE;
      cnt_r         <= CNT_ZERO;
      tx_r          <= 1'b0;
      len_r         <= {LEN_W{1'b0}};
      cur_k_vld_r   <= 1'b0;
      k             <= 7'd0;
      rxk           <= 7'd0;
      loadfreq_p    <= 1'b0;
      txen          <= 1'b0;
      rxen          <= 1'b0;
      busy          <= 1'b0;
      done_p        <= 1'b0;
      err_p         <= 1'b0;
      req.req_ready <= 1'b1;
    end else begin
      state_r       <= state_s;
      cnt_r         <= cnt_s;
      tx_r          <= tx_s;
      len_r         <= len_s;
      cur_k_vld_r   <= cur_k_vld_s;
      k             <= k_s;
      rxk           <= rxk_s;
      loadfreq_p    <= loadfreq_s;
      txen          <= txen_s;
      rxen          <= rxen_s;
      busy          <= busy_s;
      done_p        <= done_s;
      err_p         <= err_s;
      req.req_ready <= ready_s;
    end
  end

endmodule

// File: tb/tb_bt_radio_seq.sv
// -----------------------------------------------------------------------------
// tb_bt_radio_seq
// Self-checking bench for bt_radio_seq. A driver issues directed and random
// hop requests and pushes the expected hop outcome (computed from channel
// history, settle/guard times and abort points) into a queue. A monitor
// observes each hop from busy rising to busy falling, or an err_p pulse, pops
// the expectation and compares.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_bt_radio_seq;
  import bt_radio_pkg::*;

  localparam int S  = 600;
  localparam int G  = 12;
  localparam int LW = 16;

  logic       clk_6M = 1'b0;
  logic       rstz   = 1'b1;
  logic       abort  = 1'b0;
  logic [6:0] k, rxk;
  logic       loadfreq_p, txen, rxen, busy, done_p, err_p;

  always #5 clk_6M = ~clk_6M;

  bt_radio_seq_if #(.LEN_W(LW)) rbus();

  bt_radio_seq #(.SETTLE_CYC(S), .GUARD_CYC(G), .LEN_W(LW)) dut (
    .clk_6M(clk_6M), .rstz(rstz), .req(rbus), .abort(abort),
    .k(k), .rxk(rxk), .loadfreq_p(loadfreq_p), .txen(txen), .rxen(rxen),
    .busy(busy), .done_p(done_p), .err_p(err_p)
  );

  typedef struct {
    bit is_err;
    bit loaded;
    bit windowed;
    bit tx;
    int k;
    int lat;
    int win;
    int total;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // reference model: channel currently known-good in the PLL
  bit m_vld = 1'b0;
  int m_k   = 0;

  task automatic chk(input string nm, input int act, input int expv);
    n_vec++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end
  endtask

  // ---------------- monitor ----------------
  initial begin
    int  bcnt, lf, lf_k, win, lat, post, done, both, tx_seen, k_win, rxk_win;
    bit  prev_busy;
    exp_t e;
    bcnt = 0; lf = 0; lf_k = 0; win = 0; lat = 0; post = 0; done = 0;
    both = 0; tx_seen = 0; k_win = 0; rxk_win = 0; prev_busy = 1'b0;
    forever begin
      @(negedge clk_6M);
      if (!rstz) begin
        bcnt = 0; lf = 0; win = 0; post = 0; done = 0; both = 0;
        prev_busy = 1'b0;
      end else begin
        if (busy) begin
          if (txen || rxen) begin
            if (win == 0) begin
              lat     = bcnt;
              tx_seen = int'(txen);
            end
            win++;
            k_win   = int'(k);
            rxk_win = int'(rxk);
            post    = 0;
          end else if (win > 0) begin
            post++;
          end
          if (loadfreq_p) begin
            lf++;
            lf_k = int'(k);
          end
          if (done_p) done++;
          if (txen && rxen) both++;
          bcnt++;
        end else if (prev_busy) begin
          chk("hop_expected", sb.size() > 0 ? 1 : 0, 1);
          if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("hop_not_err", int'(e.is_err), 0);
            chk("loadfreq_cnt", lf, int'(e.loaded));
            if (e.loaded) chk("load_k", lf_k, e.k);
            chk("win_len", win, e.win);
            chk("done_cnt", done, int'(e.windowed));
            chk("both_en", both, 0);
            chk("ready_idle", int'(rbus.req_ready), 1);
            if (e.windowed) begin
              chk("win_latency", lat, e.lat);
              chk("win_txen", tx_seen, int'(e.tx));
              chk("win_k", k_win, e.k);
              chk("win_rxk", rxk_win, e.k);
              chk("guard_len", post, G);
            end else begin
              chk("busy_total", bcnt, e.total);
            end
          end
          bcnt = 0; lf = 0; win = 0; post = 0; done = 0; both = 0;
        end
        if (err_p) begin
          chk("err_expected", sb.size() > 0 ? 1 : 0, 1);
          if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("err_is_err", int'(e.is_err), 1);
            chk("err_busy", int'(busy), 0);
            chk("err_noload", int'(loadfreq_p), 0);
          end
        end
        prev_busy = busy;
      end
    end
  end

  // ---------------- driver ----------------
  // amode: 0 none, 1 abort in LOAD/SETTLE, 2 abort in window, 3 abort in GUARD
  task automatic do_req(input bit tx, input int kk, input int len,
                        input int amode_in, input int apar, input bit idle_ab);
    int   t, amode, wl, idx;
    exp_t e;
    t = 0;
    while (!rbus.req_ready && t < 5000) begin
      @(negedge clk_6M);
      t++;
    end
    chk("ready_wait", int'(rbus.req_ready), 1);
    rbus.req_valid = 1'b1;
    rbus.req_tx    = tx;
    rbus.req_k     = 7'(kk);
    rbus.req_len   = LW'(len);
    if (idle_ab) begin
      abort = 1'b1;
      @(negedge clk_6M);
      chk("idle_abort_busy", int'(busy), 0);
      abort = 1'b0;
    end
    e = '{default: 0};
    e.k  = kk;
    e.tx = tx;
    if (kk > BT_MAX_CH) begin
      e.is_err = 1'b1;
      sb.push_back(e);
      @(negedge clk_6M);
      rbus.req_valid = 1'b0;
      return;
    end
    amode    = amode_in;
    e.loaded = !(m_vld && m_k == kk);
    wl       = (len == 0) ? 1 : len;
    if (amode == 1 && !e.loaded) amode = 0;
    if (amode == 2 && wl < 2) amode = 0;
    e.lat      = e.loaded ? 1 + S : 0;
    e.windowed = (amode != 1);
    if (amode == 1) begin
      idx     = apar % (S + 1);
      e.win   = 0;
      e.total = idx + 1 + G;
      m_vld   = 1'b0;
    end else begin
      if (amode == 2) begin
        e.win = 1 + apar % (wl - 1);
        idx   = e.lat + e.win - 1;
      end else begin
        e.win = wl;
        idx   = e.lat + wl + 2;
      end
      m_vld = 1'b1;
      m_k   = kk;
    end
    sb.push_back(e);
    @(negedge clk_6M);
    rbus.req_valid = 1'b0;
    if (amode != 0) begin
      repeat (idx) @(negedge clk_6M);
      abort = 1'b1;
      @(negedge clk_6M);
      abort = 1'b0;
    end
  endtask

  initial begin
    int t, kk, ch;
    rbus.req_valid = 1'b0;
    rbus.req_tx    = 1'b0;
    rbus.req_k     = 7'd0;
    rbus.req_len   = {LW{1'b0}};
    #3 rstz = 1'b0;
    #20;
    chk("rst_k", int'(k), 0);
    chk("rst_rxk", int'(rxk), 0);
    chk("rst_loadfreq", int'(loadfreq_p), 0);
    chk("rst_txen", int'(txen), 0);
    chk("rst_rxen", int'(rxen), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done_p), 0);
    chk("rst_err", int'(err_p), 0);
    chk("rst_ready", int'(rbus.req_ready), 1);
    @(negedge clk_6M);
    #2 rstz = 1'b1;
    @(negedge clk_6M);

    do_req(1'b1, 10, 5, 0, 0, 1'b0);     // full load + settle
    do_req(1'b0, 10, 3, 0, 0, 1'b0);     // same channel, settle skipped
    do_req(1'b1, 79, 4, 0, 0, 1'b0);     // illegal channel
    do_req(1'b1, 20, 2, 0, 0, 1'b0);
    do_req(1'b0, 40, 7, 1, 200, 1'b0);   // abort in SETTLE
    do_req(1'b0, 40, 7, 0, 0, 1'b0);     // must reload
    do_req(1'b0, 40, 100, 2, 49, 1'b0);  // abort at window cycle 50
    do_req(1'b1, 40, 4, 0, 0, 1'b0);     // skip after window abort
    do_req(1'b1, 40, 0, 3, 0, 1'b1);     // len 0, idle abort, guard abort
    do_req(1'b0, 41, 3, 1, 0, 1'b0);     // abort in LOAD
    do_req(1'b0, 41, 3, 1, S, 1'b0);     // abort on last SETTLE cycle

    for (int i = 0; i < 20; i++) begin
      ch = $urandom_range(0, 9);
      if (ch == 0)      kk = $urandom_range(79, 127);
      else if (ch < 4)  kk = m_k;
      else              kk = $urandom_range(0, 78);
      do_req(1'($urandom_range(0, 1)), kk, $urandom_range(0, 12),
             $urandom_range(0, 3), $urandom_range(0, 1000),
             ($urandom_range(0, 5) == 0));
    end

    // asynchronous reset in the middle of an enable window
    t = 0;
    while (!rbus.req_ready && t < 5000) begin
      @(negedge clk_6M);
      t++;
    end
    rbus.req_valid = 1'b1;
    rbus.req_tx    = 1'b1;
    rbus.req_k     = 7'd33;
    rbus.req_len   = LW'(50);
    @(negedge clk_6M);
    rbus.req_valid = 1'b0;
    t = 0;
    while (!txen && t < 2000) begin
      @(negedge clk_6M);
      t++;
    end
    chk("rst_hop_window", int'(txen), 1);
    @(negedge clk_6M);
    #2 rstz = 1'b0;
    #1;
    chk("arst_txen", int'(txen), 0);
    chk("arst_rxen", int'(rxen), 0);
    chk("arst_k", int'(k), 0);
    chk("arst_busy", int'(busy), 0);
    m_vld = 1'b0;
    @(negedge clk_6M);
    @(negedge clk_6M);
    #2 rstz = 1'b1;
    @(negedge clk_6M);
    do_req(1'b1, 33, 3, 0, 0, 1'b0);     // must reload after reset

    t = 0;
    while (sb.size() > 0 && t < 3000) begin
      @(negedge clk_6M);
      t++;
    end
    chk("drain", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
